// File: rtl/fwspi_target.sv
// fwspi_target: SPI target running entirely in the system clock domain.
// sck, csn and sdi are synchronised, then edge-detected against delayed copies.
// Received words leave on the rx valid/ready stream. Transmit words are pulled
// from the tx valid/ready stream. When no tx word is offered, an all-ones filler
// word is sent instead.
// Optional feature macro: FWSPI_TARGET_MODE_SEL_EN adds the cpol/cpha inputs,
// giving runtime selection of SPI modes 0-3. Without it the block is fixed to
// mode 0.
module fwspi_target #(
  parameter int DAT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 csn,
  input  logic                 sdi,
`ifdef FWSPI_TARGET_MODE_SEL_EN
  input  logic                 cpol,
  input  logic                 cpha,
`endif
  output logic                 sdo,
  output logic                 sdo_en,
  output logic [DAT_WIDTH-1:0] rx_dat,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DAT_WIDTH-1:0] tx_dat,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 rx_overflow,
  output logic                 tx_underrun
);

  localparam int CNT_W = (DAT_WIDTH > 1) ? $clog2(DAT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DAT_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_d1_q, sck_d1_d, sck_d2_q, sck_d2_d;
  logic                   csn_d1_q, csn_d1_d, csn_d2_q, csn_d2_d;
  logic                   sdi_d1_q, sdi_d1_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DAT_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DAT_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DAT_WIDTH-1:0]   rx_dat_q, rx_dat_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   rx_overflow_q, rx_overflow_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   sdo_q, sdo_d, sdo_en_q, sdo_en_d;
`ifdef FWSPI_TARGET_MODE_SEL_EN
  logic                   cpol_q, cpol_d, cpha_q, cpha_d;
`endif

  logic sck_rise, sck_fall, csn_fall, csn_rise;
  logic sample_edge, shift_edge, load_at_sel;
  logic do_load, word_done;

  // Next-state logic: synchronisers, edge detection, frame FSM, tx load and rx handoff
  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
    csn_sync_d    = {csn_sync_q[SYNC_STAGES-2:0], csn};
    sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    sck_d1_d      = sck_sync_q[SYNC_STAGES-1];
    csn_d1_d      = csn_sync_q[SYNC_STAGES-1];
    sdi_d1_d      = sdi_sync_q[SYNC_STAGES-1];
    sck_d2_d      = sck_d1_q;
    csn_d2_d      = csn_d1_q;

    sck_rise      = sck_d1_q & ~sck_d2_q;
    sck_fall      = ~sck_d1_q & sck_d2_q;
    csn_fall      = ~csn_d1_q & csn_d2_q;
    csn_rise      = csn_d1_q & ~csn_d2_q;

`ifdef FWSPI_TARGET_MODE_SEL_EN
    // Mode is frozen for the duration of a frame.
    cpol_d        = csn_sync_q[SYNC_STAGES-1] ? cpol : cpol_q;
    cpha_d        = csn_sync_q[SYNC_STAGES-1] ? cpha : cpha_q;
    // Leading edge leaves the idle level. cpha selects which edge samples.
    sample_edge   = cpha_q ? (cpol_q ? sck_rise : sck_fall) : (cpol_q ? sck_fall : sck_rise);
    shift_edge    = cpha_q ? (cpol_q ? sck_fall : sck_rise) : (cpol_q ? sck_rise : sck_fall);
    load_at_sel   = ~cpha_q;
`else
    sample_edge   = sck_rise;
    shift_edge    = sck_fall;
    load_at_sel   = 1'b1;
`endif

    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_dat_d      = rx_dat_q;
    rx_valid_d    = rx_valid_q;
    tx_ready_d    = 1'b0;
    rx_overflow_d = 1'b0;
    tx_underrun_d = 1'b0;
    do_load       = 1'b0;
    word_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (csn_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          do_load   = load_at_sel;
        end
      end
      SHIFT: begin
        if (sample_edge) begin
          rx_shift_d = {rx_shift_q[DAT_WIDTH-2:0], sdi_d1_q};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // Deselect wins over a coincident shift/load edge, but a word completed
        // on the same cycle is still delivered.
        if (csn_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (shift_edge) begin
          if (bit_cnt_q == '0) begin
            do_load = 1'b1;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      if (tx_valid) begin
        tx_shift_d = tx_dat;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d    = '1;
        tx_underrun_d = 1'b1;
      end
    end

    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_dat_d   = rx_shift_d;
        rx_valid_d = 1'b1;
      end else begin
        rx_overflow_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    sdo_en_d = (state_d == SHIFT);
    sdo_d    = (state_d == SHIFT) & tx_shift_d[DAT_WIDTH-1];
  end

  // State and output registers. The csn chain resets to "selected", so csn held
  // low through reset does not look like a fresh falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sck_sync_q    <= '0;
      csn_sync_q    <= '0;
      sdi_sync_q    <= '0;
      sck_d1_q      <= 1'b0;
      sck_d2_q      <= 1'b0;
      csn_d1_q      <= 1'b0;
      csn_d2_q      <= 1'b0;
      sdi_d1_q      <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_dat_q      <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
      tx_underrun_q <= 1'b0;
      sdo_q         <= 1'b0;
      sdo_en_q      <= 1'b0;
`ifdef FWSPI_TARGET_MODE_SEL_EN
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      csn_sync_q    <= csn_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      sck_d1_q      <= sck_d1_d;
      sck_d2_q      <= sck_d2_d;
      csn_d1_q      <= csn_d1_d;
      csn_d2_q      <= csn_d2_d;
      sdi_d1_q      <= sdi_d1_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_dat_q      <= rx_dat_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      rx_overflow_q <= rx_overflow_d;
      tx_underrun_q <= tx_underrun_d;
      sdo_q         <= sdo_d;
      sdo_en_q      <= sdo_en_d;
`ifdef FWSPI_TARGET_MODE_SEL_EN
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
`endif
    end
  end

  assign sdo         = sdo_q;
  assign sdo_en      = sdo_en_q;
  assign rx_dat      = rx_dat_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign rx_overflow = rx_overflow_q;
  assign tx_underrun = tx_underrun_q;

endmodule
